deadlock_stall_monitor: RTL and testbench
=========================================

// Module: deadlock_stall_monitor
// PURPOSE
// - Cosim-side deadlock detector feeding the deadlock report unit. Watches per-process blocked flags
//   and a process wait-for matrix; flags a deadlock once a fixed blocked set persists STALL_THRESH cycles.
// - It then drives the hop-by-hop one-hot dl_in_vec token that the report unit traces, using the
//   report unit's origin / token_clear handshake.
// PARAMETERS
// - PROC_NUM     2     number of monitored dataflow processes (e.g. width converter, label select)
// - STALL_THRESH 1024  consecutive unchanged-blocked cycles before deadlock is declared (>=2)
// - CNT_W        16    stall counter width; must satisfy 2**CNT_W > STALL_THRESH
// PORTS
// - clock       in   1               single clock, rising edge
// - reset       in   1               asynchronous, active-high reset
// - blk_vec     in   PROC_NUM        bit i: process i stalled on a channel (_blk_n low / start FIFO)
// - wait_mat    in   PROC_NUM^2      bits [i*PROC_NUM +: PROC_NUM]: processes that process i waits on
// - origin_in   in   PROC_NUM        one-hot cycle start from report unit, valid one cycle; else 0
// - token_clear in   1               report unit: current cycle closed
// - dl_in_vec   out  PROC_NUM        to report unit: detect vector, then trace token (registered)
// - dl_active   out  1               high from detection until reset
// - stall_cnt   out  CNT_W           current stall counter (debug)
// BEHAVIOUR
// - Reset: state=S_IDLE; dl_in_vec=0, dl_active=0, stall_cnt=0, snap=0, token=0, hop=0, org=0.
// - Reset mid-operation clears everything immediately (async), including an in-progress trace.
// - S_IDLE: dl_in_vec=0. snap<=blk_vec each cycle.
//   stall_cnt<=0 if blk_vec==0 or blk_vec!=snap, else stall_cnt+1 (saturates at 2**CNT_W-1).
//   stall_ok (below) && blk_vec==snap && stall_cnt==STALL_THRESH-1 -> S_FLAG; dl_in_vec<=snap.
//   stall_ok deasserted in any cycle resets stall_cnt to 0 that cycle.
// - S_FLAG (exactly 1 cycle): dl_in_vec=snap (report unit latches it); dl_active<=1; -> S_WAIT_ORG;
//   dl_in_vec<=0.
// - S_WAIT_ORG: dl_in_vec=0. origin_in!=0 -> org<=origin_in; token<=tgt(origin_in); hop<=1; -> S_TRACE.
//   origin_in never arrives -> remain (report unit ends sim on its side).
// - tgt(v): lowest-index set bit of wait row of the lowest set bit of v, masked by snap.
//   Empty row -> 0.
// - S_TRACE: dl_in_vec=token. Each cycle token<=tgt(token), hop<=hop+1.
//   token_clear=1 -> token<=0, hop<=0, -> S_WAIT_ORG (takes priority over hop limit).
//   Closure guarantee: hop==PROC_NUM without token_clear, or tgt(token)==0, or token already visited
//   (visited mask != org) -> next token<=org, forcing the report unit to close the cycle.
// - origin_in and token_clear high in the same cycle: token_clear wins; origin_in ignored.
// - dl_active stays 1 until reset; the block never returns to S_IDLE without reset.
// - blk_vec/wait_mat ignored outside S_IDLE except for tgt() lookups (live wait_mat, frozen snap).
// - Latency: detection-cycle edge to dl_in_vec!=0 = 1 cycle. origin_in to first hop = 1 cycle.
// CONFIGURATION
// - DL_CLOSURE_CHECK_EN defined:
//   stall_ok = blk_vec!=0 && every blocked i has wait row !=0 and wait row subset of blk_vec,
//   so only closed wait-for sets count toward STALL_THRESH.
// - Undefined: stall_ok = blk_vec!=0. Any persistent blocked set is flagged
//   (earlier detection, more false alarms from leftover data).
// TESTING
// - T1: PROC_NUM=2, STALL_THRESH=8, blk_vec=2'b11, wait_mat=4'b0110 held.
//   -> dl_in_vec=2'b11 for exactly 1 cycle, 9 cycles after blk_vec first set; dl_active=1 after.
// - T2: then origin_in=2'b01 for 1 cycle -> next cycles dl_in_vec=2'b10, then 2'b01.
//   Drive token_clear on 2'b01 -> dl_in_vec=0, state S_WAIT_ORG.
// - T3: blk_vec=2'b11 for 7 cycles, one cycle 2'b01, then 2'b11 again.
//   -> counter restarts; no flag until 8 further unchanged cycles.
// - T4: after a flag, wait_mat=4'b0000 (no targets), origin_in=2'b10
//   -> dl_in_vec goes 0 then 2'b10 (forced back to org) within PROC_NUM+1 cycles.
// - T5: assert reset during S_TRACE with dl_in_vec=2'b10
//   -> dl_in_vec=0, dl_active=0, stall_cnt=0 immediately, before the next clock.
// - T6: with DL_CLOSURE_CHECK_EN, blk_vec=2'b01, wait_mat row0=2'b10 -> never flags.
//   Without the macro it flags after 8 cycles.

Source files
------------

// File: rtl/deadlock_stall_monitor.sv
// ----------------------------------------------------------------------------
// deadlock_stall_monitor
//
// Purpose:
//   Cosim-side deadlock detector. Watches the per-process blocked flags and the
//   process wait-for matrix. A deadlock is declared once the same non-empty
//   blocked set has been held for STALL_THRESH consecutive cycles. After that
//   the block drives the detect vector for one cycle. It then runs a hop-by-hop
//   one-hot trace token that the report unit follows, using the report unit's
//   origin_in / token_clear handshake.
//
// Optional feature (macro DL_CLOSURE_CHECK_EN):
//   When defined, only closed wait-for sets count toward the threshold. Every
//   blocked process must wait on at least one process, and only on processes
//   that are themselves blocked. When undefined, any persistent non-empty
//   blocked set counts.
//
// Ports:
//   clock        in   1            rising-edge clock
//   reset        in   1            asynchronous, active-high reset
//   blk_vec      in   PROC_NUM     bit i: process i stalled on a channel
//   wait_mat     in   PROC_NUM^2   [i*PROC_NUM +: PROC_NUM]: processes i waits on
//   origin_in    in   PROC_NUM     one-hot trace start from the report unit
//   token_clear  in   1            report unit closed the current cycle
//   dl_in_vec    out  PROC_NUM     detect vector, then trace token (registered)
//   dl_active    out  1            high from detection until reset
//   stall_cnt    out  CNT_W        current stall counter (debug)
// ----------------------------------------------------------------------------
module deadlock_stall_monitor #(
    parameter int unsigned PROC_NUM     = 2,
    parameter int unsigned STALL_THRESH = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_NUM-1:0]          blk_vec,
    input  logic [PROC_NUM*PROC_NUM-1:0] wait_mat,
    input  logic [PROC_NUM-1:0]          origin_in,
    input  logic                         token_clear,
    output logic [PROC_NUM-1:0]          dl_in_vec,
    output logic                         dl_active,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int unsigned HOP_W = (PROC_NUM < 2) ? 1 : $clog2(PROC_NUM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLAG,
        S_WAIT_ORG,
        S_TRACE
    } state_t;

    state_t              state_q, state_d;
    logic [PROC_NUM-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROC_NUM-1:0] dl_q, dl_d;
    logic                active_q, active_d;
    logic [PROC_NUM-1:0] token_q, token_d;
    logic [PROC_NUM-1:0] org_q, org_d;
    logic [PROC_NUM-1:0] visited_q, visited_d;
    logic [HOP_W-1:0]    hop_q, hop_d;

    logic                stall_ok;
    logic                flag_hit;
    logic [PROC_NUM-1:0] org_tgt;
    logic [PROC_NUM-1:0] tok_tgt;
    logic [PROC_NUM-1:0] tok_next;

    // Lowest set bit of the wait row belonging to the lowest set bit of v,
    // restricted to the frozen blocked set. Returns 0 for an empty row.
    function automatic logic [PROC_NUM-1:0] tgt(
        input logic [PROC_NUM-1:0]          v,
        input logic [PROC_NUM*PROC_NUM-1:0] wm,
        input logic [PROC_NUM-1:0]          msk
    );
        logic [PROC_NUM-1:0] row;
        logic [PROC_NUM-1:0] res;
        logic                found;
        row   = '0;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < PROC_NUM; i++) begin
            if (!found && v[i]) begin
                row   = wm[i*PROC_NUM +: PROC_NUM] & msk;
                found = 1'b1;
            end
        end
        found = 1'b0;
        for (int unsigned j = 0; j < PROC_NUM; j++) begin
            if (!found && row[j]) begin
                res[j] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef DL_CLOSURE_CHECK_EN
    logic [PROC_NUM-1:0] chk_row;

    always_comb begin
        stall_ok = (blk_vec != '0);
        chk_row  = '0;
        for (int unsigned i = 0; i < PROC_NUM; i++) begin
            chk_row = wait_mat[i*PROC_NUM +: PROC_NUM];
            if (blk_vec[i] && ((chk_row == '0) || ((chk_row & ~blk_vec) != '0))) begin
                stall_ok = 1'b0;
            end
        end
    end
`else
    always_comb begin
        stall_ok = (blk_vec != '0);
    end
`endif

    assign flag_hit = stall_ok && (blk_vec == snap_q) && (cnt_q == CNT_W'(STALL_THRESH - 1));
    assign org_tgt  = tgt(origin_in, wait_mat, snap_q);
    assign tok_tgt  = tgt(token_q, wait_mat, snap_q);

    // Closure guarantee: hop limit, dead end, or revisiting a non-origin node
    // sends the token back to the origin so the report unit can close the cycle.
    always_comb begin
        if ((hop_q >= HOP_W'(PROC_NUM)) || (tok_tgt == '0) ||
            ((tok_tgt & visited_q & ~org_q) != '0)) begin
            tok_next = org_q;
        end else begin
            tok_next = tok_tgt;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (flag_hit) state_d = S_FLAG;
            S_FLAG:     state_d = S_WAIT_ORG;
            S_WAIT_ORG: if (!token_clear && (origin_in != '0)) state_d = S_TRACE;
            S_TRACE:    if (token_clear) state_d = S_WAIT_ORG;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        snap_d    = snap_q;
        cnt_d     = cnt_q;
        dl_d      = '0;
        active_d  = active_q;
        token_d   = token_q;
        org_d     = org_q;
        visited_d = visited_q;
        hop_d     = hop_q;
        case (state_q)
            S_IDLE: begin
                snap_d = blk_vec;
                if (!stall_ok || (blk_vec != snap_q)) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (flag_hit) begin
                    dl_d = snap_q;
                end
            end
            S_FLAG: begin
                active_d = 1'b1;
            end
            S_WAIT_ORG: begin
                if (!token_clear && (origin_in != '0)) begin
                    org_d     = origin_in;
                    token_d   = org_tgt;
                    visited_d = origin_in | org_tgt;
                    hop_d     = HOP_W'(1);
                    dl_d      = org_tgt;
                end
            end
            S_TRACE: begin
                if (token_clear) begin
                    token_d = '0;
                    hop_d   = '0;
                end else begin
                    token_d   = tok_next;
                    visited_d = visited_q | tok_next;
                    // Saturating so the token stays parked on the origin.
                    if (hop_q < HOP_W'(PROC_NUM)) begin
                        hop_d = hop_q + 1'b1;
                    end
                    dl_d = tok_next;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q    <= '0;
            cnt_q     <= '0;
            dl_q      <= '0;
            active_q  <= 1'b0;
            token_q   <= '0;
            org_q     <= '0;
            visited_q <= '0;
            hop_q     <= '0;
        end else begin
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            dl_q      <= dl_d;
            active_q  <= active_d;
            token_q   <= token_d;
            org_q     <= org_d;
            visited_q <= visited_d;
            hop_q     <= hop_d;
        end
    end

    assign dl_in_vec = dl_q;
    assign dl_active = active_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_deadlock_stall_monitor.sv
// ----------------------------------------------------------------------------
// tb_deadlock_stall_monitor
//
// Directed bench for deadlock_stall_monitor (PROC_NUM=2, STALL_THRESH=8).
// Stimulus pushes each expected non-zero dl_in_vec value, tagged with its
// cycle, into a queue. A negedge monitor pops and compares whenever the DUT
// drives a non-zero dl_in_vec. Honours DL_CLOSURE_CHECK_EN for T6.
// ----------------------------------------------------------------------------
module tb_deadlock_stall_monitor;

    localparam int unsigned P  = 2;
    localparam int unsigned TH = 8;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [P-1:0]  blk_vec;
    logic [P*P-1:0] wait_mat;
    logic [P-1:0]  origin_in;
    logic          token_clear;
    logic [P-1:0]  dl_in_vec;
    logic          dl_active;
    logic [CW-1:0] stall_cnt;

    deadlock_stall_monitor #(
        .PROC_NUM     (P),
        .STALL_THRESH (TH),
        .CNT_W        (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .blk_vec     (blk_vec),
        .wait_mat    (wait_mat),
        .origin_in   (origin_in),
        .token_clear (token_clear),
        .dl_in_vec   (dl_in_vec),
        .dl_active   (dl_active),
        .stall_cnt   (stall_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [P-1:0] val;
        int           at;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Monitor: every non-zero dl_in_vec must match the next queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && (dl_in_vec != '0)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dl_in_vec_unexpected: cycle %0d got %b, required no output", cyc, dl_in_vec);
                end else begin
                    e = exp_q.pop_front();
                    if ((dl_in_vec !== e.val) || (cyc != e.at)) begin
                        n_fail++;
                        $display("FAIL dl_in_vec: got %b at cycle %0d, required %b at cycle %0d",
                                 dl_in_vec, cyc, e.val, e.at);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [P-1:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        blk_vec     = '0;
        wait_mat    = '0;
        origin_in   = '0;
        token_clear = 1'b0;

        // Reset state
        step(2);
        check("reset_dl_in_vec", 32'(dl_in_vec), 0);
        check("reset_dl_active", 32'(dl_active), 0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        reset = 1'b0;
        step(1);

        // T1: closed 2-cycle held -> detect vector 9 cycles later, one cycle wide
        blk_vec  = 2'b11;
        wait_mat = 4'b0110;
        push_exp(2'b11, cyc + 9);
        step(8);
        check("t1_cnt_before_flag", 32'(stall_cnt), 7);
        check("t1_active_before_flag", 32'(dl_active), 0);
        step(2);
        check("t1_active_after_flag", 32'(dl_active), 1);
        check("t1_dl_after_flag", 32'(dl_in_vec), 0);

        // T2: origin 01 -> token 10 then 01, token_clear closes it
        origin_in = 2'b01;
        push_exp(2'b10, cyc + 1);
        push_exp(2'b01, cyc + 2);
        step(1);
        origin_in = '0;
        step(1);
        token_clear = 1'b1;
        step(1);
        token_clear = 1'b0;
        check("t2_clear_dl", 32'(dl_in_vec), 0);

        // origin_in and token_clear together: origin ignored
        origin_in   = 2'b01;
        token_clear = 1'b1;
        step(1);
        origin_in   = '0;
        token_clear = 1'b0;
        step(2);
        check("t2_simul_ignored", 32'(dl_in_vec), 0);
        check("t2_active_held", 32'(dl_active), 1);

        reset   = 1'b1;
        blk_vec = '0;
        step(2);
        reset = 1'b0;
        step(1);

        // T3: one-cycle change of the blocked set restarts the counter
        blk_vec = 2'b11;
        step(7);
        check("t3_cnt_before_glitch", 32'(stall_cnt), 6);
        blk_vec = 2'b01;
        step(1);
        check("t3_cnt_restart", 32'(stall_cnt), 0);
        blk_vec = 2'b11;
        push_exp(2'b11, cyc + 9);
        step(8);
        check("t3_cnt_before_flag", 32'(stall_cnt), 7);
        check("t3_no_early_flag", 32'(dl_in_vec), 0);
        step(2);
        check("t3_active", 32'(dl_active), 1);

        // T4: empty wait rows -> token 0 then forced back to origin 10
        wait_mat  = 4'b0000;
        origin_in = 2'b10;
        push_exp(2'b10, cyc + 2);
        step(1);
        origin_in = '0;
        check("t4_first_hop_empty", 32'(dl_in_vec), 0);
        step(1);
        #5;
        check("t4_forced_origin", 32'(dl_in_vec), 2'b10);

        // T5: async reset during trace clears outputs before the next clock
        reset = 1'b1;
        #1;
        check("t5_dl_in_vec", 32'(dl_in_vec), 0);
        check("t5_dl_active", 32'(dl_active), 0);
        check("t5_stall_cnt", 32'(stall_cnt), 0);
        blk_vec  = '0;
        wait_mat = '0;
        step(2);
        reset = 1'b0;
        step(1);

        // T6: open wait-for set
        blk_vec  = 2'b01;
        wait_mat = 4'b0010;
`ifdef DL_CLOSURE_CHECK_EN
        step(20);
        check("t6_no_flag_active", 32'(dl_active), 0);
        check("t6_no_flag_cnt", 32'(stall_cnt), 0);
`else
        push_exp(2'b01, cyc + 9);
        step(12);
        check("t6_flag_active", 32'(dl_active), 1);
`endif

        step(3);
        check("expect_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
